// File: rtl/riscv_mc_pkg.sv
// Shared encodings for the multicycle RV32I controller: FSM states, opcodes and
// the datapath select/ALU codes driven by the controller.
package riscv_mc_pkg;

    typedef enum logic [3:0] {
        S_FETCH,
        S_DECODE,
        S_MEM_ADR,
        S_MEM_READ,
        S_MEM_WB,
        S_MEM_WRITE,
        S_EXEC_R,
        S_EXEC_I,
        S_ALU_WB,
        S_JAL,
        S_JALR,
        S_BRANCH,
        S_LUI
    } state_e;

    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_R      = 7'b0110011;
    localparam logic [6:0] OP_I_ALU  = 7'b0010011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_LUI    = 7'b0110111;

    localparam logic [2:0] ALU_ADD = 3'b000;
    localparam logic [2:0] ALU_SUB = 3'b001;
    localparam logic [2:0] ALU_AND = 3'b010;
    localparam logic [2:0] ALU_OR  = 3'b011;
    localparam logic [2:0] ALU_SLT = 3'b101;

    localparam logic [1:0] RES_ALUOUT = 2'b00;
    localparam logic [1:0] RES_DATA   = 2'b01;
    localparam logic [1:0] RES_ALU    = 2'b10;
    localparam logic [1:0] RES_IMM    = 2'b11;

    localparam logic [1:0] SRCA_PC    = 2'b00;
    localparam logic [1:0] SRCA_OLDPC = 2'b01;
    localparam logic [1:0] SRCA_RS1   = 2'b10;

    localparam logic [1:0] SRCB_RS2  = 2'b00;
    localparam logic [1:0] SRCB_IMM  = 2'b01;
    localparam logic [1:0] SRCB_FOUR = 2'b10;

    localparam logic [2:0] IMM_I = 3'b000;
    localparam logic [2:0] IMM_S = 3'b001;
    localparam logic [2:0] IMM_B = 3'b010;
    localparam logic [2:0] IMM_J = 3'b011;
    localparam logic [2:0] IMM_U = 3'b100;

    // Immediate format implied by the opcode; unknown opcodes fall back to I.
    function automatic logic [2:0] imm_for_op(input logic [6:0] op);
        case (op)
            OP_STORE:  return IMM_S;
            OP_BRANCH: return IMM_B;
            OP_JAL:    return IMM_J;
            OP_LUI:    return IMM_U;
            default:   return IMM_I;
        endcase
    endfunction

endpackage

// File: rtl/alu_decoder.sv
// ALU operation decode for R-type and I-type ALU instructions; funct7b5 only
// selects sub when the instruction is R-type.
import riscv_mc_pkg::*;

module alu_decoder (
    input  logic       i_r_type,
    input  logic [2:0] i_funct3,
    input  logic       i_funct7b5,
    output logic [2:0] o_alu_control
);

    // NOTE: combinational blocks assign a default first so no path leaves the output unassigned (no latch).
    always_comb begin
        o_alu_control = ALU_ADD;
        case (i_funct3)
            3'b000:  o_alu_control = (i_r_type && i_funct7b5) ? ALU_SUB : ALU_ADD;
            3'b010:  o_alu_control = ALU_SLT;
            3'b110:  o_alu_control = ALU_OR;
            3'b111:  o_alu_control = ALU_AND;
            default: o_alu_control = ALU_ADD;
        endcase
    end

endmodule

// File: rtl/multicycle_controller.sv
// Main control FSM of the multicycle RV32I core. Define MC_INSTRET_EN to build
// the retired-instruction counter and its instret port.
import riscv_mc_pkg::*;

module multicycle_controller #(
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [6:0]       op,
  input  logic [2:0]       funct3,
  input  logic             funct7b5,
  input  logic             zero,
  output logic             pc_write,
  output logic             ir_write,
  output logic             adr_src,
  output logic             mem_write,
  output logic             reg_write,
  output logic [1:0]       result_src,
  output logic [1:0]       alu_src_a,
  output logic [1:0]       alu_src_b,
  output logic [2:0]       imm_src,
  output logic [2:0]       alu_control,
  output logic             illegal
`ifdef MC_INSTRET_EN
  ,
  output logic [CNT_W-1:0] instret
`endif
);

  state_e     state;
  logic       r_type;
  logic [2:0] alu_dec;
  logic       pc_update;
  logic       branch;
  logic       taken;
  logic       ir_write_s;
  logic       mem_write_s;
  logic       reg_write_s;
  logic       illegal_s;

  assign r_type = (state == S_EXEC_R);

  alu_decoder u_alu_decoder (
    .i_r_type      (r_type),
    .i_funct3      (funct3),
    .i_funct7b5    (funct7b5),
    .o_alu_control (alu_dec)
  );

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= S_FETCH;
    end else begin
      case (state)
        S_FETCH:  state <= S_DECODE;
        S_DECODE: begin
          case (op)
            OP_LOAD, OP_STORE: state <= S_MEM_ADR;
            OP_R:              state <= S_EXEC_R;
            OP_I_ALU:          state <= S_EXEC_I;
            OP_JAL:            state <= S_JAL;
            OP_JALR:           state <= S_JALR;
            OP_BRANCH:         state <= S_BRANCH;
            OP_LUI:            state <= S_LUI;
            default:           state <= S_FETCH;
          endcase
        end
        S_MEM_ADR: begin
          if (op == OP_LOAD) state <= S_MEM_READ;
          else               state <= S_MEM_WRITE;
        end
        S_MEM_READ: state <= S_MEM_WB;
        S_EXEC_R:   state <= S_ALU_WB;
        S_EXEC_I:   state <= S_ALU_WB;
        S_JALR:     state <= S_JAL;
        S_JAL:      state <= S_ALU_WB;
        default:    state <= S_FETCH;
      endcase
    end
  end

  always_comb begin
    pc_update   = 1'b0;
    branch      = 1'b0;
    ir_write_s  = 1'b0;
    mem_write_s = 1'b0;
    reg_write_s = 1'b0;
    illegal_s   = 1'b0;
    adr_src     = 1'b0;
    result_src  = RES_ALUOUT;
    alu_src_a   = SRCA_PC;
    alu_src_b   = SRCB_RS2;
    imm_src     = IMM_I;
    alu_control = ALU_ADD;
    case (state)
      S_FETCH: begin
        ir_write_s = 1'b1;
        pc_update  = 1'b1;
        alu_src_b  = SRCB_FOUR;
        result_src = RES_ALU;
      end
      S_DECODE: begin
        alu_src_a = SRCA_OLDPC;
        alu_src_b = SRCB_IMM;
        imm_src   = imm_for_op(op);
        illegal_s = !(op inside {OP_LOAD, OP_STORE, OP_R, OP_I_ALU,
                                 OP_JAL, OP_JALR, OP_BRANCH, OP_LUI});
      end
      S_MEM_ADR: begin
        alu_src_a = SRCA_RS1;
        alu_src_b = SRCB_IMM;
        imm_src   = (op == OP_STORE) ? IMM_S : IMM_I;
      end
      S_MEM_READ: adr_src = 1'b1;
      S_MEM_WB: begin
        result_src  = RES_DATA;
        reg_write_s = 1'b1;
      end
      S_MEM_WRITE: begin
        adr_src     = 1'b1;
        mem_write_s = 1'b1;
      end
      S_EXEC_R: begin
        alu_src_a   = SRCA_RS1;
        alu_control = alu_dec;
      end
      S_EXEC_I: begin
        alu_src_a   = SRCA_RS1;
        alu_src_b   = SRCB_IMM;
        alu_control = alu_dec;
      end
      S_ALU_WB: reg_write_s = 1'b1;
      S_JALR: begin
        alu_src_a = SRCA_RS1;
        alu_src_b = SRCB_IMM;
      end
      S_JAL: begin
        alu_src_a = SRCA_OLDPC;
        alu_src_b = SRCB_FOUR;
        pc_update = 1'b1;
      end
      S_BRANCH: begin
        alu_src_a   = SRCA_RS1;
        branch      = 1'b1;
        alu_control = (funct3[2]) ? ALU_SLT : ALU_SUB;
      end
      S_LUI: begin
        imm_src     = IMM_U;
        result_src  = RES_IMM;
        reg_write_s = 1'b1;
      end
      default: ;
    endcase
  end

  // blt uses slt, so a non-zero ALU result means rs1 < rs2.
  always_comb begin
    case (funct3)
      3'b000:  taken = zero;
      3'b001:  taken = !zero;
      3'b100:  taken = !zero;
      3'b101:  taken = zero;
      default: taken = 1'b0;
    endcase
  end

  // Reset holds the FSM in FETCH, so enables are masked until it releases.
  assign pc_write  = !rst && (pc_update || (branch && taken));
  assign ir_write  = !rst && ir_write_s;
  assign mem_write = !rst && mem_write_s;
  assign reg_write = !rst && reg_write_s;
  assign illegal   = !rst && illegal_s;

`ifdef MC_INSTRET_EN
  logic             retire;
  logic [CNT_W-1:0] instret_q;

  assign retire = (state inside {S_MEM_WB, S_MEM_WRITE, S_ALU_WB, S_BRANCH, S_LUI});

  always_ff @(posedge clk or posedge rst) begin
    if (rst)         instret_q <= '0;
    else if (retire) instret_q <= instret_q + CNT_W'(1);
  end

  assign instret = instret_q;
`endif

endmodule
